// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch stage: instruction codes, the
// fetch FSM state encoding and the "no register" marker.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        PRESENT = 3'd2,
        WAIT_PC = 3'd3,
        HALT    = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_len.sv
// Combinational instruction-format lookup: byte length, presence of a
// register byte and of an 8-byte constant, and whether the icode is illegal.
module fetch_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       has_regs,
    output logic       has_valc,
    output logic       invalid
);

    always_comb begin
        len      = 4'd1;
        has_regs = 1'b0;
        has_valc = 1'b0;
        invalid  = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                len = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                len      = 4'd2;
                has_regs = 1'b1;
            end
            I_JXX, I_CALL: begin
                len      = 4'd9;
                has_valc = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len      = 4'd10;
                has_regs = 1'b1;
                has_valc = 1'b1;
            end
            default: begin
                len     = 4'd1;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial Y86-64 instruction fetch: pulls one byte per acked memory
// request, assembles the decoded fields and hands them to decode.
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | requesting bytes at PC+count until the instruction is complete
// PRESENT | decoded instruction offered to decode, waiting for out_ready
// WAIT_PC | instruction handed off, waiting for the next PC from later stages
// HALT    | halt or invalid instruction seen; only start resumes fetching
module fetch_unit
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] start_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_invalid,
    input  logic        pc_load,
    input  logic [63:0] pc_next,
    output logic        halted
);

    fetch_state_e state_q, state_d;

    logic [63:0] pc_q;
    logic [3:0]  cnt_q;
    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [63:0] valc_q, valp_q;
    logic        invalid_q;

    logic [3:0]  len_icode;
    logic [3:0]  len;
    logic        has_regs, has_valc, len_invalid;
    logic [3:0]  valc_first;
    logic        byte_ok, last_byte;
    logic        ld_start, ld_pc;

    // Byte 0 decodes straight off the bus; later bytes use the latched icode.
    assign len_icode = (cnt_q == 4'd0) ? mem_rdata[7:4] : icode_q;

    fetch_len u_len (
        .icode    (len_icode),
        .len      (len),
        .has_regs (has_regs),
        .has_valc (has_valc),
        .invalid  (len_invalid)
    );

    assign valc_first = has_regs ? 4'd2 : 4'd1;
    assign byte_ok    = (state_q == FETCH) && mem_ack;
    assign last_byte  = byte_ok && (cnt_q == (len - 4'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;
        ld_start  = 1'b0;
        ld_pc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ld_start = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (last_byte) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (icode_q == I_HALT || invalid_q) begin
                        state_d = HALT;
                    end else begin
                        state_d = WAIT_PC;
                    end
                end
            end
            WAIT_PC: begin
                if (pc_load) begin
                    ld_pc   = 1'b1;
                    state_d = FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (start) begin
                    ld_start = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Constant bytes arrive LSB first, so shifting each into the top lands
    // the first one at bits [7:0] after all eight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= 64'd0;
            cnt_q     <= 4'd0;
            icode_q   <= 4'd0;
            ifun_q    <= 4'd0;
            ra_q      <= 4'd0;
            rb_q      <= 4'd0;
            valc_q    <= 64'd0;
            valp_q    <= 64'd0;
            invalid_q <= 1'b0;
        end else if (ld_start) begin
            pc_q  <= start_pc;
            cnt_q <= 4'd0;
        end else if (ld_pc) begin
            pc_q  <= pc_next;
            cnt_q <= 4'd0;
        end else if (byte_ok) begin
            cnt_q <= last_byte ? 4'd0 : cnt_q + 4'd1;
            if (cnt_q == 4'd0) begin
                icode_q   <= mem_rdata[7:4];
                ifun_q    <= mem_rdata[3:0];
                ra_q      <= REG_NONE;
                rb_q      <= REG_NONE;
                valc_q    <= 64'd0;
                invalid_q <= len_invalid;
            end else begin
                if (has_regs && cnt_q == 4'd1) begin
                    ra_q <= mem_rdata[7:4];
                    rb_q <= mem_rdata[3:0];
                end
                if (has_valc && cnt_q >= valc_first) begin
                    valc_q <= {mem_rdata, valc_q[63:8]};
                end
            end
            if (last_byte) begin
                valp_q <= pc_q + {60'd0, len};
            end
        end
    end

    assign mem_addr      = mem_req ? (pc_q + {60'd0, cnt_q}) : 64'd0;
    assign icode         = icode_q;
    assign ifun          = ifun_q;
    assign rA            = ra_q;
    assign rB            = rb_q;
    assign valC          = valc_q;
    assign valP          = valp_q;
    assign instr_invalid = invalid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed instruction sequences with
// hand-computed fields; monitors check request addresses and handoffs.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] start_pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_invalid;
    logic        pc_load;
    logic [63:0] pc_next;
    logic        halted;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        inv;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] addr_q[$];
    exp_t        got_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [7:0]  mem [0:255];
    logic        ack_en = 1'b1;
    logic        ack_toggle = 1'b0;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_pc      (start_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .instr_invalid (instr_invalid),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_ack   = mem_req & ack_en;
        mem_rdata = mem[mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (ack_toggle) ack_en <= ~ack_en;
        else            ack_en <= 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Address and handoff monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (addr_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
            end else begin
                chk("mem_addr", mem_addr, addr_q.pop_front());
            end
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got icode %h expected no handoff", icode);
            end else begin
                got_e = exp_q.pop_front();
                chk("icode", {60'd0, icode}, {60'd0, got_e.icode});
                chk("ifun",  {60'd0, ifun},  {60'd0, got_e.ifun});
                chk("rA",    {60'd0, rA},    {60'd0, got_e.ra});
                chk("rB",    {60'd0, rB},    {60'd0, got_e.rb});
                chk("valC",  valC, got_e.valc);
                chk("valP",  valP, got_e.valp);
                chk("instr_invalid", {63'd0, instr_invalid}, {63'd0, got_e.inv});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input logic [63:0] base, input int n, input exp_t e);
        for (int i = 0; i < n; i++) addr_q.push_back(base + 64'(i));
        exp_q.push_back(e);
    endtask

    // Runs until out_valid; lat counts the first request cycle as cycle 1.
    task automatic run_instr(output int lat);
        int req;
        req = -1;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (mem_req && req < 0) req = c;
            if (out_valid) begin
                lat = c - req + 1;
                return;
            end
            step();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no out_valid expected within 60 cycles");
    endtask

    task automatic pulse_start(input logic [63:0] pc);
        start    = 1'b1;
        start_pc = pc;
        step();
        start    = 1'b0;
    endtask

    task automatic load_pc(input logic [63:0] pc);
        step();
        pc_load = 1'b1;
        pc_next = pc;
        step();
        pc_load = 1'b0;
    endtask

    initial begin
        int   lat;
        exp_t e;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2], mem[3], mem[4]}      = {8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB};
        {mem[5], mem[6], mem[7], mem[8], mem[9]}      = {8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        {mem[8'h20], mem[8'h21], mem[8'h22]}          = {8'h80, 8'h00, 8'h01};
        mem[8'h40]                                    = 8'h00;
        {mem[8'h50], mem[8'h51]}                      = {8'h60, 8'h23};
        mem[8'h80]                                    = 8'hC5;
        {mem[8'h90], mem[8'h91], mem[8'h92], mem[8'h93], mem[8'h94]} = {8'h40, 8'h12, 8'h08, 8'h07, 8'h06};
        {mem[8'h95], mem[8'h96], mem[8'h97], mem[8'h98], mem[8'h99]} = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

        rst_n     = 1'b0;
        start     = 1'b0;
        start_pc  = 64'd0;
        out_ready = 1'b1;
        pc_load   = 1'b0;
        pc_next   = 64'd0;
        #1;
        chk("rst_mem_req",   {63'd0, mem_req}, 64'd0);
        chk("rst_mem_addr",  mem_addr, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_halted",    {63'd0, halted}, 64'd0);
        chk("rst_valP",      valP, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_no_req", {63'd0, mem_req}, 64'd0);

        // irmovq $0x0123456789ABCDEF, %rbx at 0
        e = '{icode:4'h3, ifun:4'h0, ra:4'hF, rb:4'h3, valc:64'h0123456789ABCDEF, valp:64'd10, inv:1'b0};
        expect_instr(64'h0, 10, e);
        pulse_start(64'h0);
        run_instr(lat);
        chk("irmovq_latency", 64'(lat), 64'd11);

        // call 0x100 at 0x20 with a stalling memory and start held (ignored)
        e = '{icode:4'h8, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'h100, valp:64'h29, inv:1'b0};
        expect_instr(64'h20, 9, e);
        load_pc(64'h20);
        ack_toggle = 1'b1;
        start      = 1'b1;
        start_pc   = 64'hF0;
        run_instr(lat);
        start      = 1'b0;
        ack_toggle = 1'b0;

        // halt at 0x40, pc_load while halted is ignored
        e = '{icode:4'h0, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'h0, valp:64'h41, inv:1'b0};
        expect_instr(64'h40, 1, e);
        load_pc(64'h40);
        run_instr(lat);
        chk("halt_latency", 64'(lat), 64'd2);
        step();
        pc_load = 1'b1;
        pc_next = 64'h70;
        for (int i = 0; i < 4; i++) begin
            chk("halted",        {63'd0, halted}, 64'd1);
            chk("halt_no_req",   {63'd0, mem_req}, 64'd0);
            chk("halt_no_valid", {63'd0, out_valid}, 64'd0);
            step();
        end
        pc_load = 1'b0;

        // OPq at 0x50 with decode stalled for 5 cycles
        e = '{icode:4'h6, ifun:4'h0, ra:4'h2, rb:4'h3, valc:64'h0, valp:64'h52, inv:1'b0};
        expect_instr(64'h50, 2, e);
        out_ready = 1'b0;
        pulse_start(64'h50);
        run_instr(lat);
        chk("opq_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",  {63'd0, out_valid}, 64'd1);
            chk("stall_no_req", {63'd0, mem_req}, 64'd0);
            chk("stall_icode",  {60'd0, icode}, 64'h6);
            chk("stall_rA",     {60'd0, rA}, 64'h2);
            chk("stall_rB",     {60'd0, rB}, 64'h3);
            chk("stall_valP",   valP, 64'h52);
            step();
        end
        out_ready = 1'b1;

        // invalid byte C5 at 0x80 reached through pc_load
        e = '{icode:4'hC, ifun:4'h5, ra:4'hF, rb:4'hF, valc:64'h0, valp:64'h81, inv:1'b1};
        expect_instr(64'h80, 1, e);
        load_pc(64'h80);
        run_instr(lat);
        step();
        chk("invalid_halted", {63'd0, halted}, 64'd1);

        // rmmovq at 0x90 interrupted by reset after three bytes
        for (int i = 0; i < 3; i++) addr_q.push_back(64'h90 + 64'(i));
        pulse_start(64'h90);
        step();
        step();
        step();
        chk("pre_reset_req", {63'd0, mem_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req",  {63'd0, mem_req}, 64'd0);
        chk("mid_rst_mem_addr", mem_addr, 64'd0);
        chk("mid_rst_halted",   {63'd0, halted}, 64'd0);
        chk("mid_rst_fields",   {icode, ifun, rA, rB, 47'd0, instr_invalid}, 64'd0);
        chk("mid_rst_valC",     valC, 64'd0);
        chk("mid_rst_valP",     valP, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        e = '{icode:4'h4, ifun:4'h0, ra:4'h1, rb:4'h2, valc:64'h0102030405060708, valp:64'h9A, inv:1'b0};
        expect_instr(64'h90, 10, e);
        pulse_start(64'h90);
        run_instr(lat);
        chk("rmmovq_latency", 64'(lat), 64'd11);
        step();
        step();
        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
        chk("exp_q_drained",  64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
